// File: rtl/shift_issue_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the barrel-shifter issue controller.
//   DATA_W      : operand / result width
//   AMT_W       : shift-amount width
//   shift_req_t : one queued shift request (operand, amount, fill bit)
//   REQ_W       : flattened width of shift_req_t, used to size the request FIFO
// ----------------------------------------------------------------------------
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amount;
    logic              shift_in;
  } shift_req_t;

  localparam int REQ_W = $bits(shift_req_t);

endpackage

// File: rtl/shift_issue_ctrl_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with occupancy count. Push and pop may occur in the
//   same cycle, including when the FIFO is full (the pop frees the slot the
//   push lands in). A push into a full FIFO without a pop is ignored; a pop
//   from an empty FIFO is ignored.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data this cycle
//   push_data  : data to write
//   pop        : remove the head this cycle
//   pop_data   : current head (registered storage, no path from push/pop)
//   count      : number of stored entries
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // When full, a simultaneous pop makes room for the push.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head output reads 0 while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/shift_issue_ctrl.sv
// ----------------------------------------------------------------------------
// shift_issue_ctrl
//   Request buffer and issue controller in front of a non-stallable pipelined
//   barrel shifter. Requests are queued, issued one per cycle onto the Sh*
//   registers, tracked by a shadow valid pipeline of LATENCY bits, and the
//   matching ShOut values are captured in order into a result FIFO.
//
//   Handshakes (both sides): a transfer happens on a rising Clock edge where
//   valid && ready are both high. Valid, once raised, is held with stable data
//   until the transfer. ReqReady, ResValid and ResData come from registered
//   state only; neither ready nor valid depends combinationally on the other
//   side's signal.
//
//   Credit rule: a request issues only while res_count + InFlight < RES_DEPTH,
//   so every operation in the shifter has a guaranteed result FIFO slot. The
//   same-cycle result pop is deliberately ignored to keep the check short.
// Ports:
//   Clock, Reset          : clock, asynchronous active-high reset
//   ReqValid/ReqReady     : request handshake
//   ReqData/ReqAmount/ReqShiftIn : operand, left-shift amount, fill bit
//   ShIn/ShAmount/ShShiftIn      : registered operands to the shifter
//   ShOut                 : shifter result, valid when the shadow tail is set
//   ResValid/ResReady     : result handshake
//   ResData               : head of the result FIFO
//   InFlight              : operations currently inside the shifter
//   Busy                  : any FIFO non-empty or InFlight != 0
// ----------------------------------------------------------------------------
module shift_issue_ctrl
  import shift_pkg::*;
#(
  parameter int LATENCY   = 5,
  parameter int REQ_DEPTH = 4,
  parameter int RES_DEPTH = 8
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           ReqValid,
  output logic                           ReqReady,
  input  logic [DATA_W-1:0]              ReqData,
  input  logic [AMT_W-1:0]               ReqAmount,
  input  logic                           ReqShiftIn,
  output logic [DATA_W-1:0]              ShIn,
  output logic [AMT_W-1:0]               ShAmount,
  output logic                           ShShiftIn,
  input  logic [DATA_W-1:0]              ShOut,
  output logic                           ResValid,
  input  logic                           ResReady,
  output logic [DATA_W-1:0]              ResData,
  output logic [$clog2(LATENCY+1)-1:0]   InFlight,
  output logic                           Busy
);

  localparam int IF_W  = $clog2(LATENCY + 1);
  localparam int RQC_W = $clog2(REQ_DEPTH + 1);
  localparam int RSC_W = $clog2(RES_DEPTH + 1);
  localparam int CR_W  = $clog2(RES_DEPTH + LATENCY + 1);

  // Request side
  shift_req_t       req_push_data;
  shift_req_t       req_head;
  logic [RQC_W-1:0] req_count;
  logic             req_push, req_empty, req_full;

  // Result side
  logic [RSC_W-1:0] res_count;
  logic             res_push, res_pop, res_empty;

  // Issue / tracking state
  logic               ready_q, ready_d;
  logic [DATA_W-1:0]  sh_in_q, sh_in_d;
  logic [AMT_W-1:0]   sh_amount_q, sh_amount_d;
  logic               sh_shift_in_q, sh_shift_in_d;
  logic [LATENCY-1:0] shadow_q, shadow_d;
  logic [IF_W-1:0]    in_flight_q, in_flight_d;
  logic [CR_W-1:0]    credit_used;
  logic               issue;

  // ready_q holds ReqReady low through reset and for the edge that ends it.
  assign req_full  = (req_count == RQC_W'(REQ_DEPTH));
  assign req_empty = (req_count == '0);
  assign ReqReady  = ready_q && !req_full;
  assign req_push  = ReqValid && ReqReady;

  assign req_push_data.data     = ReqData;
  assign req_push_data.amount   = ReqAmount;
  assign req_push_data.shift_in = ReqShiftIn;

  // The tail of the shadow pipeline lines up with a valid ShOut.
  assign res_push  = shadow_q[LATENCY-1];
  assign res_empty = (res_count == '0);
  assign ResValid  = !res_empty;
  assign res_pop   = ResValid && ResReady;

  assign ShIn      = sh_in_q;
  assign ShAmount  = sh_amount_q;
  assign ShShiftIn = sh_shift_in_q;
  assign InFlight  = in_flight_q;
  assign Busy      = !req_empty || !res_empty || (in_flight_q != '0);

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (req_push),
    .push_data (req_push_data),
    .pop       (issue),
    .pop_data  (req_head),
    .count     (req_count)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (res_push),
    .push_data (ShOut),
    .pop       (res_pop),
    .pop_data  (ResData),
    .count     (res_count)
  );

  always_comb begin
    ready_d       = 1'b1;
    sh_in_d       = sh_in_q;
    sh_amount_d   = sh_amount_q;
    sh_shift_in_d = sh_shift_in_q;
    in_flight_d   = in_flight_q;

    credit_used = CR_W'(res_count) + CR_W'(in_flight_q);
    issue       = !req_empty && (credit_used < CR_W'(RES_DEPTH));

    if (issue) begin
      sh_in_d       = req_head.data;
      sh_amount_d   = req_head.amount;
      sh_shift_in_d = req_head.shift_in;
    end

    // Bit 0 marks "Sh* carries a new operation this cycle"; cleared on idle.
    shadow_d = (shadow_q << 1) | LATENCY'(issue);

    case ({issue, res_push})
      2'b10:   in_flight_d = in_flight_q + IF_W'(1);
      2'b01:   in_flight_d = in_flight_q - IF_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ready_q       <= 1'b0;
      sh_in_q       <= '0;
      sh_amount_q   <= '0;
      sh_shift_in_q <= 1'b0;
      shadow_q      <= '0;
      in_flight_q   <= '0;
    end else begin
      ready_q       <= ready_d;
      sh_in_q       <= sh_in_d;
      sh_amount_q   <= sh_amount_d;
      sh_shift_in_q <= sh_shift_in_d;
      shadow_q      <= shadow_d;
      in_flight_q   <= in_flight_d;
    end
  end

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_shift_issue_ctrl
//   Bench for shift_issue_ctrl with a behavioural shifter whose ShOut lines up
//   with the controller's shadow tail. Accepted requests push their expected
//   shift result into exp_q; every result pop is compared against the head.
// ----------------------------------------------------------------------------
module tb_shift_issue_ctrl;

  localparam int LATENCY   = 5;
  localparam int REQ_DEPTH = 4;
  localparam int RES_DEPTH = 8;

  // ---------------------------------------------------------------- clock/reset
  logic        Clock      = 1'b0;
  logic        Reset      = 1'b0;
  logic        ReqValid   = 1'b0;
  logic [31:0] ReqData    = '0;
  logic [4:0]  ReqAmount  = '0;
  logic        ReqShiftIn = 1'b0;
  logic        ResReady   = 1'b0;
  logic        ReqReady;
  logic [31:0] ShIn;
  logic [4:0]  ShAmount;
  logic        ShShiftIn;
  logic [31:0] ShOut;
  logic        ResValid;
  logic [31:0] ResData;
  logic [2:0]  InFlight;
  logic        Busy;

  always #5 Clock = ~Clock;

  shift_issue_ctrl #(
    .LATENCY   (LATENCY),
    .REQ_DEPTH (REQ_DEPTH),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqData    (ReqData),
    .ReqAmount  (ReqAmount),
    .ReqShiftIn (ReqShiftIn),
    .ShIn       (ShIn),
    .ShAmount   (ShAmount),
    .ShShiftIn  (ShShiftIn),
    .ShOut      (ShOut),
    .ResValid   (ResValid),
    .ResReady   (ResReady),
    .ResData    (ResData),
    .InFlight   (InFlight),
    .Busy       (Busy)
  );

  // ---------------------------------------------------------------- reference
  function automatic logic [31:0] shift_model(input logic [31:0] d,
                                              input logic [4:0]  a,
                                              input logic        si);
    logic [31:0] fill;
    fill = si ? ((32'h1 << a) - 32'h1) : 32'h0;
    return (d << a) | fill;
  endfunction

  // Shifter stand-in: not reset, so stale values keep flowing after a reset.
  logic [31:0] pipe [LATENCY-1];
  always @(posedge Clock) begin
    pipe[0] <= shift_model(ShIn, ShAmount, ShShiftIn);
    for (int i = 1; i < LATENCY - 1; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end
  assign ShOut = pipe[LATENCY-2];

  // ---------------------------------------------------------------- scoreboard
  int          checks   = 0;
  int          errors   = 0;
  int          accepted = 0;
  int          popped   = 0;
  logic [31:0] exp_q[$];

  always @(negedge Clock) begin
    logic [31:0] e;
    if (!Reset) begin
      if (ResValid && ResReady) begin
        checks++;
        popped++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL res_unexpected got %h required none", ResData);
        end else begin
          e = exp_q.pop_front();
          if (ResData !== e) begin
            errors++;
            $display("FAIL res_data got %h required %h", ResData, e);
          end
        end
      end
      if (ReqValid && ReqReady) begin
        exp_q.push_back(shift_model(ReqData, ReqAmount, ReqShiftIn));
        accepted++;
      end
    end
  end

  // A capture into a full result FIFO without a pop would lose a result.
  always @(negedge Clock) begin
    if (!Reset && dut.res_push && !dut.res_pop && (int'(dut.res_count) == RES_DEPTH)) begin
      errors++;
      $display("FAIL res_overflow got count %0d with capture required below %0d",
               dut.res_count, RES_DEPTH);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- drivers
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic rand_req();
    ReqData    = $urandom();
    ReqAmount  = 5'($urandom_range(0, 31));
    ReqShiftIn = 1'($urandom_range(0, 1));
  endtask

  task automatic send_burst(input int n, output int not_ready);
    not_ready = 0;
    for (int i = 0; i < n; i++) begin
      ReqValid = 1'b1;
      rand_req();
      if (ReqReady !== 1'b1) not_ready++;
      @(posedge Clock);
      #1;
    end
    ReqValid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int waited);
    waited = 0;
    while ((Busy !== 1'b0) && (waited < budget)) begin
      @(posedge Clock);
      #1;
      waited++;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    ReqValid = 1'b0;
    ResReady = 1'b0;
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({ReqReady, ResValid, Busy} !== 3'b000 || InFlight !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b infl=%0d required all 0",
               ReqReady, ResValid, Busy, InFlight);
    end
    checks++;
    if (ResData !== 32'h0 || ShIn !== 32'h0 || ShAmount !== 5'h0 || ShShiftIn !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got res=%h shin=%h amt=%h si=%b required all 0",
               ResData, ShIn, ShAmount, ShShiftIn);
    end
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (ReqReady !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got %b required 0", ReqReady);
    end
    @(posedge Clock);
    #1;
    checks++;
    if (ReqReady !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_edge got rdy=%b busy=%b required rdy=1 busy=0", ReqReady, Busy);
    end
  endtask

  task automatic test_single(input logic [31:0] d, input logic [4:0] a, input logic si);
    int n;
    ResReady   = 1'b1;
    ReqValid   = 1'b1;
    ReqData    = d;
    ReqAmount  = a;
    ReqShiftIn = si;
    checks++;
    if (ReqReady !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b required 1", ReqReady);
    end
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
    n = 0;
    while (ResValid !== 1'b1 && n < 20) begin
      @(posedge Clock);
      #1;
      n++;
      if (n == 1) begin
        checks++;
        if (ShIn !== d || ShAmount !== a || ShShiftIn !== si || InFlight !== 3'd1) begin
          errors++;
          $display("FAIL single_issue got %h/%0d/%b infl=%0d required %h/%0d/%b infl=1",
                   ShIn, ShAmount, ShShiftIn, InFlight, d, a, si);
        end
      end
    end
    checks++;
    if (n != LATENCY + 1) begin
      errors++;
      $display("FAIL single_latency got %0d required %0d", n, LATENCY + 1);
    end
    @(posedge Clock);
    #1;
    checks++;
    if (ResValid !== 1'b0 || Busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain got vld=%b busy=%b pending=%0d required 0/0/0",
               ResValid, Busy, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int first, last, vcount, not_ready, pop0;
    first = -1; last = -1; vcount = 0; not_ready = 0; pop0 = popped;
    ResReady = 1'b1;
    for (int c = 0; c < 16 + LATENCY + 8; c++) begin
      if (c < 16) begin
        ReqValid = 1'b1;
        rand_req();
        if (ReqReady !== 1'b1) not_ready++;
      end else begin
        ReqValid = 1'b0;
      end
      @(posedge Clock);
      #1;
      if (ResValid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        vcount++;
      end
    end
    checks++;
    if (not_ready != 0) begin
      errors++;
      $display("FAIL b2b_ready got %0d low cycles required 0", not_ready);
    end
    checks++;
    if (vcount != 16 || last - first != 15) begin
      errors++;
      $display("FAIL b2b_rate got %0d valid over span %0d required 16 over 15", vcount, last - first);
    end
    checks++;
    if (popped - pop0 != 16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got %0d pending %0d required 16 pending 0", popped - pop0, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int acc0, pop0, last_acc, offered, waited;
    acc0 = accepted; pop0 = popped; last_acc = accepted;
    ResReady = 1'b0;
    ReqValid = 1'b1;
    rand_req();
    offered = 1;
    repeat (40) begin
      @(posedge Clock);
      #1;
      if (accepted != last_acc) begin
        last_acc = accepted;
        if (offered < 20) begin
          rand_req();
          offered++;
        end else begin
          ReqValid = 1'b0;
        end
      end
    end
    checks++;
    if (accepted - acc0 != RES_DEPTH + REQ_DEPTH) begin
      errors++;
      $display("FAIL bp_accepted got %0d required %0d", accepted - acc0, RES_DEPTH + REQ_DEPTH);
    end
    checks++;
    if (ReqReady !== 1'b0 || InFlight !== 3'd0 || ResValid !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall got rdy=%b infl=%0d vld=%b busy=%b required 0/0/1/1",
               ReqReady, InFlight, ResValid, Busy);
    end
    ReqValid = 1'b0;
    ResReady = 1'b1;
    wait_idle(60, waited);
    checks++;
    if (Busy !== 1'b0 || popped - pop0 != RES_DEPTH + REQ_DEPTH || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got busy=%b popped=%0d pending=%0d required 0/%0d/0",
               Busy, popped - pop0, exp_q.size(), RES_DEPTH + REQ_DEPTH);
    end
  endtask

  // The credit rule keeps res_count + InFlight <= RES_DEPTH, so the tightest
  // reachable case is a capture and a pop together with 7 of 8 slots used.
  task automatic test_full_capture_pop();
    int nr, pop0, waited;
    pop0 = popped;
    ResReady = 1'b0;
    send_burst(10, nr);
    idle_cycles(10);
    checks++;
    if (nr != 0 || InFlight !== 3'd0 || int'(dut.res_count) != RES_DEPTH || ReqReady !== 1'b1) begin
      errors++;
      $display("FAIL full_fill got nr=%0d infl=%0d cnt=%0d rdy=%b required 0/0/%0d/1",
               nr, InFlight, dut.res_count, ReqReady, RES_DEPTH);
    end
    ResReady = 1'b1;
    @(posedge Clock);
    #1;
    ResReady = 1'b0;
    @(posedge Clock);
    #1;
    checks++;
    if (InFlight !== 3'd1) begin
      errors++;
      $display("FAIL full_refill got infl=%0d required 1", InFlight);
    end
    idle_cycles(LATENCY - 1);
    ResReady = 1'b1;
    @(posedge Clock);
    #1;
    ResReady = 1'b0;
    checks++;
    if (int'(dut.res_count) != RES_DEPTH - 1 || InFlight !== 3'd0) begin
      errors++;
      $display("FAIL full_cap_pop got cnt=%0d infl=%0d required %0d/0",
               dut.res_count, InFlight, RES_DEPTH - 1);
    end
    ResReady = 1'b1;
    wait_idle(60, waited);
    checks++;
    if (Busy !== 1'b0 || popped - pop0 != 10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_drain got busy=%b popped=%0d pending=%0d required 0/10/0",
               Busy, popped - pop0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int nr, bad;
    ResReady = 1'b0;
    send_burst(10, nr);
    @(posedge Clock);
    #1;
    checks++;
    if (nr != 0 || InFlight !== 3'd3 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got nr=%0d infl=%0d busy=%b required 0/3/1", nr, InFlight, Busy);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({ReqReady, ResValid, Busy, ShShiftIn} !== 4'b0000 || InFlight !== 3'd0 ||
        ResData !== 32'h0 || ShIn !== 32'h0 || ShAmount !== 5'h0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b vld=%b busy=%b infl=%0d res=%h shin=%h required all 0",
               ReqReady, ResValid, Busy, InFlight, ResData, ShIn);
    end
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < LATENCY + 3; i++) begin
      @(posedge Clock);
      #1;
      if (ResValid !== 1'b0 || Busy !== 1'b0 || InFlight !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_stale got %0d cycles with activity required 0", bad);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_single(32'h0000_0001, 5'd31, 1'b0);
    test_single(32'hDEAD_BEEF, 5'd4, 1'b1);
    test_back_to_back();
    test_backpressure();
    test_full_capture_pop();
    test_reset_mid();
    test_single(32'h1234_5678, 5'd0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
